mem_port_arbiter: RTL
=====================

# mem_port_arbiter

- Shares the single memory request/response port between two requesters: port 0 is the fetch engine; port 1 is the writeback/host path.
- Requests are arbitrated round-robin into a registered output stage.
- Memory returns responses in request order, so an ordering FIFO records the requester ID of every accepted request and routes each response back to its owner.
- The block sits between the requesters and the memory model/controller.

## Interface

Parameters:
- ADDR_WIDTH, default from constants_pkg: request address width.
- DATA_WIDTH, default from constants_pkg: response data width.
- MAX_OUTSTANDING, default 4: ordering-FIFO depth. Must be a power of 2, ≥2. It is the maximum number of accepted requests whose response has not yet been delivered.

Ports (clock and reset first):
- clk  in  1  system clock, single clock domain; everything is on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- rq_vld  in  2  per-port request valid; bit i belongs to port i.
- rq_rdy  out  2  per-port request ready.
- rq_addr0, rq_addr1  in  ADDR_WIDTH  per-port request address.
- rs_vld  out  2  per-port response valid.
- rs_rdy  in  2  per-port response ready.
- rs_data  out  DATA_WIDTH  response data, shared by both ports; qualified by rs_vld.
- m_req_vld  out  1  memory request valid (registered).
- m_req_rdy  in  1  memory request ready.
- m_req_addr  out  ADDR_WIDTH  memory request address (registered).
- m_rsp_vld  in  1  memory response valid.
- m_rsp_rdy  out  1  memory response ready.
- m_rsp_data  in  DATA_WIDTH  memory response data.
- busy  out  1  high when the FIFO is non-empty or m_req_vld is high.

## Operation

- **Handshake:** a transfer occurs on a cycle where vld && rdy. Once asserted, vld and payload hold until that transfer.
- **Load enable:** load = (!m_req_vld || m_req_rdy) && (fifo_cnt < MAX_OUTSTANDING) && |rq_vld.
  - The full check is conservative: a same-cycle pop does not free a slot for a same-cycle push.
- **Grant selection:**
  - Only port i valid: grant port i.
  - Both ports valid: grant the port that is not last_grant.
- **Grant effect:**
  - rq_rdy[g] = load && (grant == g); the other bit is 0.
  - rq_rdy may depend combinationally on rq_vld.
- **On load:**
  - m_req_vld <= 1 and m_req_addr <= rq_addr of the granted port.
  - The granted ID is pushed into the FIFO.
  - last_grant <= grant.
- **When not loading:** if m_req_vld && m_req_rdy, then m_req_vld <= 0; otherwise the stage holds.
- **Response routing:**
  - head = FIFO head ID.
  - rs_vld[i] = m_rsp_vld && fifo_cnt != 0 && head == i.
  - rs_data = m_rsp_data.
  - m_rsp_rdy = fifo_cnt != 0 && rs_rdy[head].
  - The FIFO pops on m_rsp_vld && m_rsp_rdy.
- **Response with empty FIFO:** this is a protocol error. m_rsp_rdy stays 0 and no rs_vld asserts; the response stalls and is never dropped silently.
- **FIFO pointers:** log2(MAX_OUTSTANDING) bits with natural wrap-around. fifo_cnt is log2(MAX_OUTSTANDING)+1 bits.
- **Simultaneous push and pop** (when not full): fifo_cnt is unchanged and both pointers advance.
- **Backpressure:**
  - A stalled owner (rs_rdy low) stalls m_rsp_rdy.
  - This head-of-line blocking is accepted by design: memory is in-order.

## Timing

- **Reset values:**
  - Forced while rst_n = 0: rq_rdy=0, rs_vld=0, m_rsp_rdy=0.
  - Registered reset values: m_req_vld=0, m_req_addr=0, busy=0, fifo_cnt=0, pointers=0.
  - last_grant=1, so port 0 wins the first tie.
- **Reset mid-operation:** the FIFO and output stage clear immediately. In-flight responses are forgotten, so memory must be reset together with this block.
- **Request latency:** a request accepted in cycle N appears on m_req_vld/m_req_addr in cycle N+1.
- **Throughput:** one request per cycle with m_req_rdy held high; the stage reloads in the same cycle it is consumed.
- **Response latency:** combinational pass-through, 0 cycles from m_rsp to rs_*.
- **Fairness:** with both ports continuously valid and memory ready, grants alternate 0,1,0,1…
- **Full FIFO:** with fifo_cnt == MAX_OUTSTANDING, rq_rdy = 2'b00 until the cycle after the first pop.

## Test plan

- **Reset:** hold rst_n=0 with rq_vld=2'b11 -> rq_rdy=2'b00, m_req_vld=0, busy=0. Release -> the next edge loads port 0's address; m_req_vld=1 one cycle later.
- **Round-robin:** both ports always valid, m_req_rdy=1, port 0 address 0x10+k, port 1 address 0x80+k, memory echoing address as data after 2 cycles -> m_req_addr sequence 0x10,0x80,0x11,0x81. Each response lands only on the owning port: rs_vld[0] for 0x10, rs_vld[1] for 0x80.
- **Outstanding limit:** MAX_OUTSTANDING=4, memory withholds responses, port 0 streams -> exactly 4 requests accepted, then rq_rdy[0]=0. One response returned -> a 5th request is accepted on the following cycle.
- **Memory backpressure:** m_req_rdy=0 for 3 cycles with a loaded request -> m_req_addr stable, rq_rdy=2'b00. m_req_rdy=1 -> the next request is loaded in the same cycle.
- **Response stall:** port 1 owns the head and rs_rdy[1]=0 for 5 cycles while port 0's response is queued behind it -> m_rsp_rdy=0 and rs_vld[0]=0 throughout. Delivery resumes in order after rs_rdy[1]=1.
- **Reset mid-stream:** assert rst_n=0 with 3 outstanding requests -> fifo_cnt=0, m_req_vld=0 and busy=0 within the same cycle (asynchronous), with no spurious rs_vld.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin two-port memory request arbiter with in-order response routing
package constants_pkg;
    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 32;
endpackage

module mem_port_arbiter #(
    parameter int ADDR_WIDTH      = constants_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH      = constants_pkg::DATA_WIDTH,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            rq_vld,
    output logic [1:0]            rq_rdy,
    input  logic [ADDR_WIDTH-1:0] rq_addr0,
    input  logic [ADDR_WIDTH-1:0] rq_addr1,
    output logic [1:0]            rs_vld,
    input  logic [1:0]            rs_rdy,
    output logic [DATA_WIDTH-1:0] rs_data,
    output logic                  m_req_vld,
    input  logic                  m_req_rdy,
    output logic [ADDR_WIDTH-1:0] m_req_addr,
    input  logic                  m_rsp_vld,
    output logic                  m_rsp_rdy,
    input  logic [DATA_WIDTH-1:0] m_rsp_data,
    output logic                  busy
);
    localparam int PW = $clog2(MAX_OUTSTANDING);

    logic [MAX_OUTSTANDING-1:0] fifo_id;
    logic [PW-1:0]              wr_ptr;
    logic [PW-1:0]              rd_ptr;
    logic [PW:0]                fifo_cnt;
    logic                       last_grant;
    logic                       grant;
    logic                       load;
    logic                       head;
    logic                       not_empty;
    logic                       pop;

    // rst_n gates load so rq_rdy stays low while reset is held
    always_comb begin
        grant     = (rq_vld == 2'b11) ? ~last_grant : rq_vld[1];
        load      = rst_n && (!m_req_vld || m_req_rdy) && !fifo_cnt[PW] && |rq_vld;
        rq_rdy    = {load && grant, load && !grant};
        not_empty = fifo_cnt != '0;
        head      = fifo_id[rd_ptr];
        rs_vld    = {m_rsp_vld && not_empty && head, m_rsp_vld && not_empty && !head};
        rs_data   = m_rsp_data;
        m_rsp_rdy = not_empty && rs_rdy[head];
        pop       = m_rsp_vld && m_rsp_rdy;
        busy      = not_empty || m_req_vld;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_req_vld  <= 1'b0;
            m_req_addr <= '0;
            last_grant <= 1'b1;
            fifo_id    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
        end else begin
            if (load) begin
                m_req_vld       <= 1'b1;
                m_req_addr      <= grant ? rq_addr1 : rq_addr0;
                last_grant      <= grant;
                fifo_id[wr_ptr] <= grant;
                wr_ptr          <= wr_ptr + 1'b1;
            end else if (m_req_rdy) begin
                m_req_vld <= 1'b0;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt + {{PW{1'b0}}, load} - {{PW{1'b0}}, pop};
        end
    end
endmodule
